// File: rtl/run_check_pkg.sv
// Shared types for the CPU run-and-check harness.
//   state_e       : harness FSM states
//   check_entry_t : one check-table record {valid, addr, data}
// Table entry widths come from the CHK_* localparams below; the top-level
// DATA_W/ADDR_W/NUM_CHECKS parameters default to these values.
package run_check_pkg;

   localparam int unsigned CHK_DATA_W     = 32;
   localparam int unsigned CHK_ADDR_W     = 4;
   localparam int unsigned CHK_NUM_CHECKS = 4;
   localparam int unsigned CHK_IDX_W      = (CHK_NUM_CHECKS > 1) ? $clog2(CHK_NUM_CHECKS) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StReset,
      StRun,
      StCheck,
      StDone
   } state_e;

   typedef struct packed {
      logic                  valid;
      logic [CHK_ADDR_W-1:0] addr;
      logic [CHK_DATA_W-1:0] data;
   } check_entry_t;

endpackage

// File: rtl/check_table.sv
// Check-table storage: NUM_CHECKS entries of check_entry_t.
//   clk, rst       : clock, synchronous active-high clear of every entry
//   we/widx/wentry : synchronous write port
//   ridx/rentry    : combinational read port
module check_table
   import run_check_pkg::*;
#(
   parameter int unsigned NUM_CHECKS = CHK_NUM_CHECKS,
   parameter int unsigned IDX_W      = CHK_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  check_entry_t     wentry,
   input  logic [IDX_W-1:0] ridx,
   output check_entry_t     rentry
);

   check_entry_t table_q [NUM_CHECKS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHECKS; i++) begin
            table_q[i] <= '0;
         end
      end else if (we && (int'(widx) < NUM_CHECKS)) begin
         table_q[widx] <= wentry;
      end
   end

   // Out-of-range indices (non power-of-two depth) read as an invalid entry.
   always_comb begin
      rentry = '0;
      if (int'(ridx) < NUM_CHECKS) begin
         rentry = table_q[ridx];
      end
   end

endmodule

// File: rtl/cpu_run_checker.sv
// Run-and-check harness around the processor.
// Holds the CPU in reset for RST_CYCLES, lets it run run_cycles cycles, then freezes
// it and walks the check table (one entry per cycle), comparing register-file reads
// against expected values.
//   clk, rst                 : clock, synchronous active-high reset
//   start, run_cycles        : launch a run (accepted in IDLE/DONE only)
//   cfg_we/idx/valid/addr/data : check-table write (accepted in IDLE/DONE only)
//   cpu_rst, cpu_hold        : processor reset / freeze request
//   rf_raddr, rf_rdata       : register-file debug read port
//   busy, done, pass         : status
//   fail_idx, fail_data      : first mismatching entry and the value read there
//   fail_cnt, chk_cnt        : mismatch count, compared-entry count
module cpu_run_checker
   import run_check_pkg::*;
#(
   parameter int unsigned DATA_W     = CHK_DATA_W,
   parameter int unsigned ADDR_W     = CHK_ADDR_W,
   parameter int unsigned NUM_CHECKS = CHK_NUM_CHECKS,
   parameter int unsigned CYCLE_W    = 16,
   parameter int unsigned RST_CYCLES = 1,
   localparam int unsigned IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CYCLE_W-1:0] run_cycles,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic               cfg_valid,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [DATA_W-1:0]  cfg_data,
   output logic               cpu_rst,
   output logic               cpu_hold,
   output logic [ADDR_W-1:0]  rf_raddr,
   input  logic [DATA_W-1:0]  rf_rdata,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [IDX_W-1:0]   fail_idx,
   output logic [DATA_W-1:0]  fail_data,
   output logic [IDX_W:0]     fail_cnt,
   output logic [IDX_W:0]     chk_cnt
);

   localparam int unsigned CNT_W = IDX_W + 1;

   state_e             state_q, state_d;
   logic [CYCLE_W-1:0] cnt_q;
   logic [CYCLE_W-1:0] run_len_q;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   fail_idx_q;
   logic [DATA_W-1:0]  fail_data_q;
   logic [CNT_W-1:0]   fail_cnt_q;
   logic [CNT_W-1:0]   chk_cnt_q;

   logic         cfg_ok;
   logic         start_ok;
   logic         last_rst;
   logic         last_run;
   logic         last_idx;
   logic         mismatch;
   check_entry_t cfg_entry;
   check_entry_t cur_entry;

   assign cfg_ok   = (state_q == StIdle) || (state_q == StDone);
   assign start_ok = start && cfg_ok;
   assign last_rst = (cnt_q == CYCLE_W'(RST_CYCLES - 1));
   assign last_run = (cnt_q == (run_len_q - CYCLE_W'(1)));
   assign last_idx = (idx_q == IDX_W'(NUM_CHECKS - 1));
   assign mismatch = cur_entry.valid && (rf_rdata != cur_entry.data);

   always_comb begin
      cfg_entry       = '0;
      cfg_entry.valid = cfg_valid;
      cfg_entry.addr  = cfg_addr;
      cfg_entry.data  = cfg_data;
   end

   check_table #(
      .NUM_CHECKS (NUM_CHECKS),
      .IDX_W      (IDX_W)
   ) u_check_table (
      .clk    (clk),
      .rst    (rst),
      .we     (cfg_we && cfg_ok),
      .widx   (cfg_idx),
      .wentry (cfg_entry),
      .ridx   (idx_q),
      .rentry (cur_entry)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) state_d = StReset;
         end
         StReset: begin
            // A zero-length run goes straight to checking; the CPU never runs unheld.
            if (last_rst) state_d = (run_len_q == '0) ? StCheck : StRun;
         end
         StRun: begin
            if (last_run) state_d = StCheck;
         end
         StCheck: begin
            if (last_idx) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      cpu_rst  = (state_q == StIdle) || (state_q == StReset);
      cpu_hold = (state_q == StCheck) || (state_q == StDone);
      busy     = (state_q == StReset) || (state_q == StRun) || (state_q == StCheck);
      done     = (state_q == StDone);
      rf_raddr = '0;
      if (state_q == StCheck) rf_raddr = cur_entry.addr;
   end

   // Counters and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         run_len_q   <= '0;
         idx_q       <= '0;
         fail_idx_q  <= '0;
         fail_data_q <= '0;
         fail_cnt_q  <= '0;
         chk_cnt_q   <= '0;
      end else if (start_ok) begin
         cnt_q       <= '0;
         run_len_q   <= run_cycles;
         idx_q       <= '0;
         fail_idx_q  <= '0;
         fail_data_q <= '0;
         fail_cnt_q  <= '0;
         chk_cnt_q   <= '0;
      end else begin
         case (state_q)
            StReset, StRun: begin
               // One counter serves both phases; it restarts on every phase change.
               cnt_q <= (state_d != state_q) ? '0 : cnt_q + CYCLE_W'(1);
            end
            StCheck: begin
               idx_q <= last_idx ? '0 : idx_q + IDX_W'(1);
               if (cur_entry.valid) begin
                  chk_cnt_q <= chk_cnt_q + CNT_W'(1);
                  if (mismatch) begin
                     if (fail_cnt_q == '0) begin
                        fail_idx_q  <= idx_q;
                        fail_data_q <= rf_rdata;
                     end
                     fail_cnt_q <= fail_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign pass      = done && (fail_cnt_q == '0) && (chk_cnt_q != '0);
   assign fail_idx  = fail_idx_q;
   assign fail_data = fail_data_q;
   assign fail_cnt  = fail_cnt_q;
   assign chk_cnt   = chk_cnt_q;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Bench for cpu_run_checker. A small processor model supplies the register file:
// it clears on cpu_rst, and on each unheld running edge advances pc, writing
// r8=11 when pc==5 and r3=7 when pc==7.
module tb_cpu_run_checker;

   localparam int RST_CYC = 1;
   localparam int NCHK    = 4;
   localparam int NV      = 7;

   typedef struct packed {
      logic        v;
      logic [3:0]  a;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      ent_t [3:0] e;
      int         run;
      int         ex_pass;
      int         ex_chk;
      int         ex_fail;
      int         ex_fidx;
      int         ex_fdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, cfg_we, cfg_valid;
   logic [15:0] run_cycles;
   logic [1:0]  cfg_idx;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cpu_rst, cpu_hold, busy, done, pass;
   logic [3:0]  rf_raddr;
   logic [31:0] rf_rdata, fail_data;
   logic [1:0]  fail_idx;
   logic [2:0]  fail_cnt, chk_cnt;

   logic [31:0] regs [16];
   int          pc;
   int          n_checks = 0;
   int          n_fail   = 0;
   vec_t        vecs [NV];

   always #5 clk = ~clk;

   cpu_run_checker #(
      .CYCLE_W    (16),
      .RST_CYCLES (RST_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .run_cycles (run_cycles),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_valid  (cfg_valid),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cpu_rst    (cpu_rst),
      .cpu_hold   (cpu_hold),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .fail_idx   (fail_idx),
      .fail_data  (fail_data),
      .fail_cnt   (fail_cnt),
      .chk_cnt    (chk_cnt)
   );

   assign rf_rdata = regs[rf_raddr];

   always @(posedge clk) begin
      if (cpu_rst === 1'b1) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         pc <= 0;
      end else if (cpu_hold === 1'b0) begin
         pc <= pc + 1;
         if (pc == 5) regs[8] <= 32'd11;
         if (pc == 7) regs[3] <= 32'd7;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic ent_t mk(input bit v, input int a, input int d);
      ent_t e;
      e.v = v;
      e.a = a[3:0];
      e.d = d;
      return e;
   endfunction

   function automatic vec_t mkv(input int run, input int p, input int c, input int f,
                                input int fi, input int fd);
      vec_t x;
      x.e        = '0;
      x.run      = run;
      x.ex_pass  = p;
      x.ex_chk   = c;
      x.ex_fail  = f;
      x.ex_fidx  = fi;
      x.ex_fdata = fd;
      return x;
   endfunction

   task automatic pulse_rst();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic write_entry(input int i, input ent_t e);
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_idx   = i[1:0];
      cfg_valid = e.v;
      cfg_addr  = e.a;
      cfg_data  = e.d;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   // Start is captured on the posedge inside this task (edge t).
   task automatic launch(input int r);
      @(negedge clk);
      start      = 1'b1;
      run_cycles = r[15:0];
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // k counts edges after t; done seen after edge t+k is first sampled high at t+k+1.
   task automatic wait_done(input int k0, output int lat);
      int k;
      k = k0;
      while (done !== 1'b1 && k < 400) begin
         @(posedge clk);
         k++;
         #1;
      end
      check("done_reached", done, 1);
      lat = k + 1;
   endtask

   initial begin
      int lat;
      rst        = 1'b1;
      start      = 1'b0;
      cfg_we     = 1'b0;
      cfg_idx    = '0;
      cfg_valid  = 1'b0;
      cfg_addr   = '0;
      cfg_data   = '0;
      run_cycles = '0;

      // run, pass, chk_cnt, fail_cnt, fail_idx, fail_data
      vecs[0] = mkv(50, 1, 1, 0, 0, 0);
      vecs[0].e[0] = mk(1, 8, 11);
      vecs[1] = mkv(50, 0, 2, 1, 0, 11);
      vecs[1].e[0] = mk(1, 8, 1);
      vecs[1].e[2] = mk(1, 8, 11);
      vecs[2] = mkv(0, 1, 1, 0, 0, 0);
      vecs[2].e[0] = mk(1, 8, 0);
      vecs[3] = mkv(5, 0, 2, 1, 1, 0);
      vecs[3].e[1] = mk(1, 8, 11);
      vecs[3].e[3] = mk(1, 3, 0);
      vecs[4] = mkv(6, 0, 2, 1, 1, 0);
      vecs[4].e[0] = mk(1, 8, 11);
      vecs[4].e[1] = mk(1, 3, 7);
      vecs[5] = mkv(10, 0, 0, 0, 0, 0);
      vecs[6] = mkv(20, 0, 4, 2, 0, 11);
      vecs[6].e[0] = mk(1, 8, 5);
      vecs[6].e[1] = mk(1, 3, 9);
      vecs[6].e[2] = mk(1, 8, 11);
      vecs[6].e[3] = mk(1, 3, 7);

      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_raddr", rf_raddr, 0);
      check("rst_chk_cnt", chk_cnt, 0);
      check("rst_fail_cnt", fail_cnt, 0);
      @(negedge clk) rst = 1'b0;

      for (int v = 0; v < NV; v++) begin
         pulse_rst();
         for (int i = 0; i < 4; i++) begin
            if (vecs[v].e[i].v) write_entry(i, vecs[v].e[i]);
         end
         launch(vecs[v].run);
         check("busy_after_start", busy, 1);
         wait_done(0, lat);
         check("latency", lat, RST_CYC + vecs[v].run + NCHK + 1);
         check("pass", pass, vecs[v].ex_pass);
         check("chk_cnt", chk_cnt, vecs[v].ex_chk);
         check("fail_cnt", fail_cnt, vecs[v].ex_fail);
         check("fail_idx", fail_idx, vecs[v].ex_fidx);
         check("fail_data", fail_data, vecs[v].ex_fdata);
         check("cpu_run_len", pc, vecs[v].run);
         check("done_hold", cpu_hold, 1);
         check("done_cpu_rst", cpu_rst, 0);
         check("done_busy", busy, 0);
      end

      // start and cfg_we during RUN are ignored
      pulse_rst();
      write_entry(0, mk(1, 8, 11));
      launch(50);
      repeat (10) @(posedge clk);
      @(negedge clk);
      start      = 1'b1;
      run_cycles = 16'd3;
      cfg_we     = 1'b1;
      cfg_idx    = 2'd0;
      cfg_valid  = 1'b1;
      cfg_addr   = 4'd8;
      cfg_data   = 32'd99;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cfg_we = 1'b0;
      check("midrun_busy", busy, 1);
      wait_done(11, lat);
      check("midrun_latency", lat, RST_CYC + 50 + NCHK + 1);
      check("midrun_pass", pass, 1);
      check("midrun_chk_cnt", chk_cnt, 1);
      check("midrun_fail_cnt", fail_cnt, 0);

      // rst mid-run aborts and clears the table
      pulse_rst();
      write_entry(0, mk(1, 8, 11));
      launch(50);
      repeat (10) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_cpu_rst", cpu_rst, 1);
      check("abort_done", done, 0);
      @(negedge clk) rst = 1'b0;
      launch(10);
      wait_done(0, lat);
      check("abort_latency", lat, RST_CYC + 10 + NCHK + 1);
      check("abort_chk_cnt", chk_cnt, 0);
      check("abort_pass", pass, 0);

      // start and cfg_we in the same IDLE cycle: the write is used by the run
      pulse_rst();
      @(negedge clk);
      start      = 1'b1;
      run_cycles = 16'd20;
      cfg_we     = 1'b1;
      cfg_idx    = 2'd1;
      cfg_valid  = 1'b1;
      cfg_addr   = 4'd3;
      cfg_data   = 32'd7;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cfg_we = 1'b0;
      wait_done(0, lat);
      check("same_cycle_latency", lat, RST_CYC + 20 + NCHK + 1);
      check("same_cycle_pass", pass, 1);
      check("same_cycle_chk_cnt", chk_cnt, 1);
      check("same_cycle_fail_cnt", fail_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
